// File: rtl/imm_gen_pkg.sv
// Shared format-select codes and instruction field slicers for the immediate generator.
// Each slicer returns its field sign-extended to 32 bits, with inst[31] as the sign bit.
package imm_gen_pkg;

    localparam int unsigned INST_W  = 32;
    localparam int unsigned EXT_W   = 6;
    localparam int unsigned SHAMT_W = 6;
    localparam int unsigned ZIMM_W  = 5;

    localparam logic [EXT_W-1:0] EXT_CTRL_ITYPE_SHAMT = 6'd0;
    localparam logic [EXT_W-1:0] EXT_CTRL_ITYPE       = 6'd1;
    localparam logic [EXT_W-1:0] EXT_CTRL_STYPE       = 6'd2;
    localparam logic [EXT_W-1:0] EXT_CTRL_BTYPE       = 6'd3;
    localparam logic [EXT_W-1:0] EXT_CTRL_UTYPE       = 6'd4;
    localparam logic [EXT_W-1:0] EXT_CTRL_JTYPE       = 6'd5;
    localparam logic [EXT_W-1:0] EXT_CTRL_CSR_ZIMM    = 6'd6;

    function automatic logic [INST_W-1:0] imm_i(input logic [INST_W-1:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic [INST_W-1:0] imm_s(input logic [INST_W-1:0] inst);
        return {{20{inst[31]}}, inst[31:25], inst[11:7]};
    endfunction

    function automatic logic [INST_W-1:0] imm_b(input logic [INST_W-1:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [INST_W-1:0] imm_u(input logic [INST_W-1:0] inst);
        return {inst[31:12], 12'b0};
    endfunction

    function automatic logic [INST_W-1:0] imm_j(input logic [INST_W-1:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational RV32I/RV64I immediate decoder: raw instruction + format select -> XLEN immediate.
// Also usable standalone by a single-cycle core.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [INST_W-1:0] inst_i,
    input  logic [EXT_W-1:0]  ext_op_i,
    output logic [XLEN-1:0]   imm_c_o
);

    logic [SHAMT_W-1:0] shamt;
    logic [ZIMM_W-1:0]  zimm;
    logic               unused_opcode;

    // RV64 shifts use a 6-bit shamt; RV32 only 5 bits
    assign shamt         = (XLEN == 64) ? inst_i[25:20] : {1'b0, inst_i[24:20]};
    assign zimm          = inst_i[19:15];
    assign unused_opcode = ^inst_i[6:0];

    always_comb begin
        imm_c_o = '0;
        case (ext_op_i)
            EXT_CTRL_ITYPE_SHAMT: imm_c_o = XLEN'(shamt);
            EXT_CTRL_ITYPE:       imm_c_o = XLEN'($signed(imm_i(inst_i)));
            EXT_CTRL_STYPE:       imm_c_o = XLEN'($signed(imm_s(inst_i)));
            EXT_CTRL_BTYPE:       imm_c_o = XLEN'($signed(imm_b(inst_i)));
            EXT_CTRL_UTYPE:       imm_c_o = XLEN'($signed(imm_u(inst_i)));
            EXT_CTRL_JTYPE:       imm_c_o = XLEN'($signed(imm_j(inst_i)));
            EXT_CTRL_CSR_ZIMM:    imm_c_o = XLEN'(zimm);
            default:              imm_c_o = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator between decode and execute: one-cycle latency,
// valid/ready on both sides, 2-entry skid (main + skid register), synchronous flush.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] inst,
    input  logic [EXT_W-1:0]  EXTOp,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   immout,
    output logic [TAG_W-1:0]  out_tag
);

    logic [XLEN-1:0]  dec_imm;
    logic             accept;
    logic             advance;

    logic             main_valid_q, main_valid_d;
    logic [XLEN-1:0]  main_imm_q,   main_imm_d;
    logic [TAG_W-1:0] main_tag_q,   main_tag_d;
    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
    logic             in_ready_q,   in_ready_d;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .inst_i   (inst),
        .ext_op_i (EXTOp),
        .imm_c_o  (dec_imm)
    );

    assign accept  = in_valid && in_ready_q;
    assign advance = !main_valid_q || out_ready;

    // Next-state: flush wins; a draining main takes the skid entry first, else the new input
    always_comb begin
        main_valid_d = main_valid_q;
        main_imm_d   = main_imm_q;
        main_tag_d   = main_tag_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (advance) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_imm_d   = skid_imm_q;
                main_tag_d   = skid_tag_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_imm_d = dec_imm;
                    main_tag_d = in_tag;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm;
            skid_tag_d   = in_tag;
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_valid_q <= 1'b0;
            main_imm_q   <= '0;
            main_tag_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_imm_q   <= main_imm_d;
            main_tag_q   <= main_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_tag_q   <= skid_tag_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign immout    = main_imm_q;
    assign out_tag   = main_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus;
// a scoreboard queue predicts the XLEN=32 output stream.
module tb_imm_gen_pipe;

    localparam int unsigned TAG_W = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic              flush;
    logic              in_valid;
    logic              out_ready;
    logic [31:0]       inst;
    logic [5:0]        ext_op;
    logic [TAG_W-1:0]  in_tag;

    logic              in_ready, out_valid;
    logic [31:0]       immout;
    logic [TAG_W-1:0]  out_tag;
    logic              in_ready64, out_valid64;
    logic [63:0]       immout64;
    logic [TAG_W-1:0]  out_tag64;

    typedef struct packed {
        logic [31:0]      imm;
        logic [TAG_W-1:0] tag;
    } sb_t;

    sb_t sb_q[$];
    int  total = 0;
    int  bad   = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .EXTOp(ext_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .immout(immout), .out_tag(out_tag)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .inst(inst), .EXTOp(ext_op), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .immout(immout64), .out_tag(out_tag64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decode for XLEN=32, written from the format table
    function automatic logic [31:0] model_imm(input logic [31:0] i, input logic [5:0] op);
        logic s;
        s = i[31];
        case (op)
            6'd0:    return {27'b0, i[24:20]};
            6'd1:    return {{20{s}}, i[31:20]};
            6'd2:    return {{20{s}}, i[31:25], i[11:7]};
            6'd3:    return {{19{s}}, s, i[7], i[30:25], i[11:8], 1'b0};
            6'd4:    return {i[31:12], 12'h000};
            6'd5:    return {{11{s}}, s, i[19:12], i[20], i[30:21], 1'b0};
            6'd6:    return {27'b0, i[19:15]};
            default: return 32'h0;
        endcase
    endfunction

    // One clock: check pre-edge state against the model, update scoreboard, advance
    task automatic step();
        logic        acc, fire, hold;
        logic [31:0] h_imm;
        logic [3:0]  h_tag;
        sb_t         e;
        chk("in_ready", 64'(in_ready), 64'(sb_q.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(sb_q.size() > 0));
        acc   = in_valid && (sb_q.size() < 2);
        fire  = (sb_q.size() > 0) && out_ready && !flush;
        hold  = (sb_q.size() > 0) && !out_ready && !flush;
        h_imm = immout;
        h_tag = out_tag;
        if (fire) begin
            e = sb_q.pop_front();
            chk("sb_imm", 64'(immout), 64'(e.imm));
            chk("sb_tag", 64'(out_tag), 64'(e.tag));
        end
        if (flush) begin
            sb_q.delete();
        end else if (acc) begin
            e.imm = model_imm(inst, ext_op);
            e.tag = in_tag;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (hold) begin
            chk("stable_valid", 64'(out_valid), 64'd1);
            chk("stable_imm", 64'(immout), 64'(h_imm));
            chk("stable_tag", 64'(out_tag), 64'(h_tag));
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic [5:0] op, input logic [3:0] t);
        in_valid = 1'b1;
        inst     = i;
        ext_op   = op;
        in_tag   = t;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) step();
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        inst = '0; ext_op = '0; in_tag = '0;

        // Reset state
        #8;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_immout", 64'(immout), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_in_ready64", 64'(in_ready64), 64'd1);
        #2 rstn = 1'b1;

        // Decode of the test-plan instructions, back to back with out_ready=1
        out_ready = 1'b1;
        drive(32'hFFF00093, 6'd1, 4'd5); step();
        chk("addi_imm", 64'(immout), 64'hFFFF_FFFF);
        chk("addi_tag", 64'(out_tag), 64'd5);
        chk("addi_valid", 64'(out_valid), 64'd1);
        drive(32'hFE000EE3, 6'd3, 4'd6); step();
        chk("beq_imm", 64'(immout), 64'hFFFF_FFFC);
        drive(32'h123450B7, 6'd4, 4'd7); step();
        chk("lui_imm", 64'(immout), 64'h1234_5000);
        drive(32'h03F09093, 6'd0, 4'd8); step();
        chk("slli32_imm", 64'(immout), 64'h1F);
        chk("slli64_imm", immout64, 64'h3F);
        chk("slli64_tag", 64'(out_tag64), 64'd8);
        drive(32'hFFFFFFFF, 6'd7, 4'd9); step();
        chk("bad_op32", 64'(immout), 64'd0);
        chk("bad_op64", immout64, 64'd0);
        drive(32'h800000B7, 6'd4, 4'd10); step();
        chk("lui32_neg", 64'(immout), 64'h8000_0000);
        chk("lui64_neg", immout64, 64'hFFFF_FFFF_8000_0000);
        drive(32'h000FD073, 6'd6, 4'd11); step();
        chk("zimm32", 64'(immout), 64'h1F);
        chk("zimm64", immout64, 64'h1F);
        drain();

        // Backpressure: tags 1,2 accepted, 3 held upstream, then released in order
        out_ready = 1'b0;
        drive(32'h00100093, 6'd1, 4'd1); step();
        drive(32'h00200093, 6'd1, 4'd2); step();
        drive(32'h00300093, 6'd1, 4'd3);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        step();
        chk("bp_hold_tag", 64'(out_tag), 64'd1);
        step();
        chk("bp_hold_imm", 64'(immout), 64'd1);
        out_ready = 1'b1;
        step();
        chk("bp_tag2", 64'(out_tag), 64'd2);
        step();
        chk("bp_tag3", 64'(out_tag), 64'd3);
        in_valid = 1'b0;
        step();
        chk("empty_valid", 64'(out_valid), 64'd0);
        chk("empty_imm_kept", 64'(immout), 64'd3);

        // Flush with both registers full and a concurrent push
        out_ready = 1'b0;
        drive(32'h00400093, 6'd1, 4'd4); step();
        drive(32'h00500093, 6'd1, 4'd5); step();
        drive(32'h00900093, 6'd1, 4'd9); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        step();
        out_ready = 1'b1;
        drive(32'h00A00093, 6'd1, 4'd10); step();
        chk("post_flush_tag", 64'(out_tag), 64'd10);
        chk("post_flush_imm", 64'(immout), 64'hA);
        drain();

        // Asynchronous reset mid-cycle with both registers full
        out_ready = 1'b0;
        drive(32'h00C00093, 6'd1, 4'd12); step();
        drive(32'h00D00093, 6'd1, 4'd13); step();
        in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_imm", 64'(immout), 64'd0);
        chk("arst_tag", 64'(out_tag), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_valid64", 64'(out_valid64), 64'd0);
        sb_q.delete();
        #1 rstn = 1'b1;
        out_ready = 1'b1;
        drive(32'h00E00093, 6'd1, 4'd14); step();
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_imm", 64'(immout), 64'hE);
        chk("post_rst_tag", 64'(out_tag), 64'd14);
        drain();

        // Random traffic with random backpressure
        for (int n = 0; n < 60; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            inst      = $urandom;
            ext_op    = 6'($urandom_range(0, 8));
            in_tag    = 4'($urandom_range(0, 15));
            step();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
